pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline.
- Detects load-use hazards between the Decode/Execute buffer and the instruction in decode.
- Handles taken-branch flushes and multi-cycle data-memory waits.
- Drives write-enables and bubble/flush strobes to the PC, Fetch/Decode, Decode/Execute and Execute/Memory buffers.
- Raises a sticky error on memory timeout and keeps saturating performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait handling with timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             deMemToRead_i,
    input  logic [4:0]       deRtAddr_i,
    input  logic [4:0]       fdRsAddr_i,
    input  logic [4:0]       fdRtAddr_i,
    input  logic             fdUsesRt_i,
    input  logic             branchTaken_i,
    input  logic             memReq_i,
    input  logic             memReady_i,
    output logic             pcWrite_o,
    output logic             fdWrite_o,
    output logic             fdFlush_o,
    output logic             deWrite_o,
    output logic             deBubble_o,
    output logic             emWrite_o,
    output logic             mwBubble_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stallCnt_o,
    output logic [CNT_W-1:0] flushCnt_o
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StError   = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e            stateQ, stateD;
    logic [15:0]       toutQ, toutD;
    logic [15:0]       toutInc;
    logic [CNT_W-1:0]  stallCntQ, stallCntD;
    logic [CNT_W-1:0]  flushCntQ, flushCntD;
    logic              memStall, loadUse;

    assign memStall = memReq_i & ~memReady_i;
    assign loadUse  = deMemToRead_i & (deRtAddr_i != 5'd0) &
                      ((deRtAddr_i == fdRsAddr_i) | (fdUsesRt_i & (deRtAddr_i == fdRtAddr_i)));
    assign toutInc  = toutQ + 16'd1;

    always_comb begin
        pcWrite_o  = 1'b1;
        fdWrite_o  = 1'b1;
        deWrite_o  = 1'b1;
        emWrite_o  = 1'b1;
        fdFlush_o  = 1'b0;
        deBubble_o = 1'b0;
        mwBubble_o = 1'b0;
        stateD     = stateQ;
        toutD      = toutQ;

        unique case (stateQ)
            StRun: begin
                if (memStall) begin
                    {pcWrite_o, fdWrite_o, deWrite_o, emWrite_o} = 4'b0000;
                    mwBubble_o = 1'b1;
                    stateD     = StMemWait;
                    toutD      = 16'd1;
                end else if (branchTaken_i) begin
                    // Wrong-path instruction in decode, so any load-use is moot.
                    fdFlush_o  = 1'b1;
                    deBubble_o = 1'b1;
                end else if (loadUse) begin
                    pcWrite_o  = 1'b0;
                    fdWrite_o  = 1'b0;
                    deBubble_o = 1'b1;
                end
            end
            StMemWait: begin
                if (!memReady_i) begin
                    {pcWrite_o, fdWrite_o, deWrite_o, emWrite_o} = 4'b0000;
                    mwBubble_o = 1'b1;
                    toutD      = toutInc;
                    if ({16'd0, toutInc} >= MEM_TIMEOUT) begin
                        stateD = StError;
                    end
                end else begin
                    // Completion: evaluate as RUN without a memory stall.
                    if (branchTaken_i) begin
                        fdFlush_o  = 1'b1;
                        deBubble_o = 1'b1;
                    end else if (loadUse) begin
                        pcWrite_o  = 1'b0;
                        fdWrite_o  = 1'b0;
                        deBubble_o = 1'b1;
                    end
                    stateD = StRun;
                    toutD  = 16'd0;
                end
            end
            StError: begin
                {pcWrite_o, fdWrite_o, deWrite_o, emWrite_o} = 4'b0000;
                mwBubble_o = 1'b1;
            end
            default: begin
                stateD = StRun;
                toutD  = 16'd0;
            end
        endcase

        if (!rst_ni) begin
            {pcWrite_o, fdWrite_o, deWrite_o, emWrite_o} = 4'b0000;
            fdFlush_o  = 1'b0;
            deBubble_o = 1'b0;
            mwBubble_o = 1'b0;
        end
    end

    always_comb begin
        stallCntD = stallCntQ;
        flushCntD = flushCntQ;
        if (!pcWrite_o && stallCntQ != CntMax) begin
            stallCntD = stallCntQ + CntOne;
        end
        if (fdFlush_o && flushCntQ != CntMax) begin
            flushCntD = flushCntQ + CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ    <= StRun;
            toutQ     <= 16'd0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            toutQ     <= toutD;
            stallCntQ <= stallCntD;
            flushCntQ <= flushCntD;
        end
    end

    assign err_o      = (stateQ == StError);
    assign state_o    = stateQ;
    assign stallCnt_o = stallCntQ;
    assign flushCnt_o = flushCntQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic       deMemToRead, fdUsesRt, branchTaken, memReq, memReady;
    logic [4:0] deRtAddr, fdRsAddr, fdRtAddr;
    logic       pcWrite, fdWrite, fdFlush, deWrite, deBubble, emWrite, mwBubble, err;
    logic [1:0] state;
    logic [3:0] stallCnt, flushCnt;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .deMemToRead_i(deMemToRead),
        .deRtAddr_i   (deRtAddr),
        .fdRsAddr_i   (fdRsAddr),
        .fdRtAddr_i   (fdRtAddr),
        .fdUsesRt_i   (fdUsesRt),
        .branchTaken_i(branchTaken),
        .memReq_i     (memReq),
        .memReady_i   (memReady),
        .pcWrite_o    (pcWrite),
        .fdWrite_o    (fdWrite),
        .fdFlush_o    (fdFlush),
        .deWrite_o    (deWrite),
        .deBubble_o   (deBubble),
        .emWrite_o    (emWrite),
        .mwBubble_o   (mwBubble),
        .err_o        (err),
        .state_o      (state),
        .stallCnt_o   (stallCnt),
        .flushCnt_o   (flushCnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        deMemToRead = 1'b0; fdUsesRt = 1'b0; branchTaken = 1'b0;
        memReq = 1'b0; memReady = 1'b0;
        deRtAddr = 5'd0; fdRsAddr = 5'd0; fdRtAddr = 5'd0;
    endtask

    task automatic doReset();
        #2 rstN = 1'b0;
        #1;
        checkVal("rst_state", int'(state), 0);
        checkVal("rst_stallCnt", int'(stallCnt), 0);
        rstN = 1'b1;
        tick();
    endtask

    initial begin
        clearInputs();
        rstN = 1'b0;
        #3;
        checkVal("rst_pcWrite", int'(pcWrite), 0);
        checkVal("rst_emWrite", int'(emWrite), 0);
        checkVal("rst_mwBubble", int'(mwBubble), 0);
        checkVal("rst_err", int'(err), 0);
        checkVal("rst_state0", int'(state), 0);
        #9 rstN = 1'b1;
        tick();

        // Idle defaults
        checkVal("idle_pcWrite", int'(pcWrite), 1);
        checkVal("idle_fdWrite", int'(fdWrite), 1);
        checkVal("idle_deWrite", int'(deWrite), 1);
        checkVal("idle_fdFlush", int'(fdFlush), 0);

        // Load-use on rs: one bubble
        deMemToRead = 1'b1; deRtAddr = 5'd9; fdRsAddr = 5'd9; fdRtAddr = 5'd3;
        #1;
        checkVal("lu_pcWrite", int'(pcWrite), 0);
        checkVal("lu_fdWrite", int'(fdWrite), 0);
        checkVal("lu_deBubble", int'(deBubble), 1);
        checkVal("lu_deWrite", int'(deWrite), 1);
        tick();
        deMemToRead = 1'b0;
        #1;
        checkVal("lu_after_pcWrite", int'(pcWrite), 1);
        checkVal("lu_after_deBubble", int'(deBubble), 0);
        checkVal("lu_stallCnt", int'(stallCnt), 1);

        // rt path only counts when decode reads rt
        deMemToRead = 1'b1; deRtAddr = 5'd5; fdRsAddr = 5'd1; fdRtAddr = 5'd5; fdUsesRt = 1'b1;
        #1;
        checkVal("lu_rt_pcWrite", int'(pcWrite), 0);
        fdUsesRt = 1'b0;
        #1;
        checkVal("lu_rt_unused_pcWrite", int'(pcWrite), 1);
        // $zero destination never stalls
        deRtAddr = 5'd0; fdRsAddr = 5'd0;
        #1;
        checkVal("lu_zero_pcWrite", int'(pcWrite), 1);
        checkVal("lu_zero_deBubble", int'(deBubble), 0);
        tick();
        checkVal("lu_zero_stallCnt", int'(stallCnt), 1);
        clearInputs();

        // Branch beats load-use
        doReset();
        branchTaken = 1'b1; deMemToRead = 1'b1; deRtAddr = 5'd9; fdRsAddr = 5'd9;
        #1;
        checkVal("br_fdFlush", int'(fdFlush), 1);
        checkVal("br_deBubble", int'(deBubble), 1);
        checkVal("br_pcWrite", int'(pcWrite), 1);
        checkVal("br_fdWrite", int'(fdWrite), 1);
        tick();
        clearInputs();
        #1;
        checkVal("br_flushCnt", int'(flushCnt), 1);
        checkVal("br_stallCnt", int'(stallCnt), 0);
        checkVal("br_after_fdFlush", int'(fdFlush), 0);

        // Memory wait: 3 stalled cycles then release
        memReq = 1'b1; memReady = 1'b0;
        #1;
        checkVal("mw_pcWrite", int'(pcWrite), 0);
        checkVal("mw_emWrite", int'(emWrite), 0);
        checkVal("mw_mwBubble", int'(mwBubble), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("mw_state", int'(state), 1);
        end
        memReady = 1'b1;
        #1;
        checkVal("mw_rel_pcWrite", int'(pcWrite), 1);
        checkVal("mw_rel_emWrite", int'(emWrite), 1);
        checkVal("mw_rel_mwBubble", int'(mwBubble), 0);
        checkVal("mw_stallCnt", int'(stallCnt), 3);
        tick();
        checkVal("mw_rel_state", int'(state), 0);
        clearInputs();

        // Release with pending branch
        memReq = 1'b1; memReady = 1'b0;
        tick();
        checkVal("mwb_state_wait", int'(state), 1);
        memReady = 1'b1; branchTaken = 1'b1;
        #1;
        checkVal("mwb_fdFlush", int'(fdFlush), 1);
        checkVal("mwb_deBubble", int'(deBubble), 1);
        checkVal("mwb_pcWrite", int'(pcWrite), 1);
        checkVal("mwb_emWrite", int'(emWrite), 1);
        tick();
        clearInputs();
        checkVal("mwb_state", int'(state), 0);
        checkVal("mwb_flushCnt", int'(flushCnt), 2);
        checkVal("mwb_stallCnt", int'(stallCnt), 4);

        // Timeout after 4 stalled cycles
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checkVal("to_state_pre", int'(state), 1);
        checkVal("to_err_pre", int'(err), 0);
        tick();
        checkVal("to_state", int'(state), 2);
        checkVal("to_err", int'(err), 1);
        memReq = 1'b0; memReady = 1'b1; branchTaken = 1'b1;
        #1;
        checkVal("err_pcWrite", int'(pcWrite), 0);
        checkVal("err_fdFlush", int'(fdFlush), 0);
        checkVal("err_mwBubble", int'(mwBubble), 1);
        tick();
        checkVal("err_sticky_state", int'(state), 2);
        clearInputs();
        #2 rstN = 1'b0;
        #1;
        checkVal("arst_state", int'(state), 0);
        checkVal("arst_err", int'(err), 0);
        checkVal("arst_stallCnt", int'(stallCnt), 0);
        checkVal("arst_pcWrite", int'(pcWrite), 0);
        rstN = 1'b1;
        tick();
        checkVal("arst_rel_pcWrite", int'(pcWrite), 1);

        // Stall counter saturates at 15
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checkVal("sat_stallCnt14", int'(stallCnt), 14);
        for (int i = 0; i < 6; i++) tick();
        checkVal("sat_stallCnt", int'(stallCnt), 15);
        checkVal("sat_state", int'(state), 2);
        clearInputs();

        // Reset mid-MEM_WAIT returns to RUN with nothing pending
        doReset();
        memReq = 1'b1; memReady = 1'b0;
        tick();
        checkVal("mwr_state", int'(state), 1);
        clearInputs();
        doReset();
        #1;
        checkVal("mwr_after_state", int'(state), 0);
        checkVal("mwr_after_pcWrite", int'(pcWrite), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
